string_byte_serializer: RTL and testbench
=========================================

// Module: string_byte_serializer
// PURPOSE
//  Consumes a packed Verilog string (a value built by {..} concat / {N{..}} replication,
//  right-justified, left-padded with NUL) and emits it one character per transfer, first
//  character first, over a valid/ready byte stream. Sits downstream of string-packing logic,
//  feeding a character sink (console/UART model, display formatter).
// PARAMETERS
//  NCHARS         20  capacity in characters; load_data width is 8*NCHARS
//  SKIP_LEAD_NUL  1   1: drop leading NUL bytes before sending; 0: send all NCHARS bytes
// PORTS
//  clk         in   1              rising-edge clock, single clock domain
//  reset       in   1              asynchronous, active-high reset
//  load_valid  in   1              load_data is valid
//  load_ready  out  1              block accepts a load (high only in IDLE)
//  load_data   in   8*NCHARS       packed string; byte [8*NCHARS-1 -: 8] is the first char
//  out_valid   out  1              out_char is valid
//  out_ready   in   1              sink accepts out_char
//  out_char    out  8              current character
//  out_last    out  1              qualifies out_char as the final character of the string
//  busy        out  1              state != IDLE
//  remaining   out  CW             unsent chars incl. current; CW = $clog2(NCHARS+1)
//  done        out  1              one-cycle pulse when a string completes (incl. empty string)
// BEHAVIOUR
//  Reset (async): state=IDLE, shift reg=0, remaining=0; out_valid=0, out_char=0,
//   out_last=0, busy=0, done=0, load_ready=1 after reset deasserts.
//  States IDLE, SCAN, SEND:
//   IDLE: load_ready=1. load_valid&load_ready at edge E0 -> capture load_data,
//    remaining=NCHARS; next state SCAN if SKIP_LEAD_NUL else SEND.
//   SCAN: per cycle: remaining==0 -> IDLE, done=1 next cycle (all-NUL string, nothing
//    sent); top byte==0 -> shift left 8, remaining-=1; top byte!=0 -> SEND.
//    k leading NULs => out_valid first high after edge E0+k+1; SKIP_LEAD_NUL=0 => after E0.
//   SEND: out_valid=1, out_char=top byte, out_last=(remaining==1). On out_valid&out_ready:
//    shift left 8, remaining-=1; if out_last -> IDLE and done pulses for the next cycle.
//    out_valid, out_char, out_last held stable while out_ready=0 (no drop, no duplicate).
//  Only leading NULs are skipped; NULs after the first non-NUL char are sent verbatim.
//  load_valid ignored outside IDLE (no queueing); a load can be accepted in the cycle done
//   is high (back-to-back strings, 1 idle cycle minimum between strings).
//  out_char=0 and out_last=0 whenever out_valid=0. remaining never underflows.
//  reset mid-SCAN/SEND aborts immediately; no done pulse; partial string discarded.
// STRUCTURE
//  Shared package: state enum (IDLE/SCAN/SEND), CHAR_W=8, NUL=8'h00 constant.
//  Single module; no sub-module: one 8*NCHARS shift register, one CW-bit down-counter,
//  3-state FSM. Datapath shift left by CHAR_W only; no barrel shifter.
// TESTING
//  1 NCHARS=20, load {"ABC:"} (16 leading NUL), out_ready=1 -> out 41,42,43,3A; out_last on
//    3A only; first out_valid 17 edges after accept; done 1 cycle after 3A transfer.
//  2 Load {5{"hello"}} (25 chars, NCHARS=25), out_ready toggling 1/0 each cycle -> exactly 25
//    bytes "hellohello..." in order, out_char stable across every stalled cycle.
//  3 Load all-zero -> out_valid never high; done pulses 21 edges after accept; busy falls with it.
//  4 Load 24'h410042 (NCHARS=3) -> out 41,00,42; SKIP_LEAD_NUL=0 with {"AB"} (NCHARS=4)
//    -> out 00,00,41,42.
//  5 Assert reset after 2nd char of "XYZ:" -> outputs return to reset values same cycle; next
//    load of "Q" emits only 51 with out_last.
//  6 Hold load_valid high with "ab" then "cd" presented during SEND -> second load ignored
//    until IDLE; accepted in done cycle; stream 61,62,63,64, two done pulses.

Source files
------------

// File: rtl/string_byte_serializer_pkg.sv
// Shared definitions for the string byte serializer.
//   state_t : FSM states (IDLE waits for a load, SCAN drops leading NULs,
//             SEND presents one character per transfer)
//   CHAR_W  : width of one character in the packed string
//   NUL     : padding character used to left-fill packed strings
package string_byte_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int          CHAR_W = 8;
    localparam logic [7:0]  NUL    = 8'h00;

endpackage

// File: rtl/string_byte_serializer.sv
// string_byte_serializer
//   Takes a right-justified, NUL-left-padded packed string and streams it out
//   one character per transfer, first (most significant) character first.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   load_valid : load_data is valid
//   load_ready : a load is accepted (high only while idle)
//   load_data  : packed string, byte [8*NCHARS-1 -: 8] is the first character
//   out_valid  : out_char is valid
//   out_ready  : sink accepts out_char
//   out_char   : current character (0 when out_valid is low)
//   out_last   : out_char is the final character of the string
//   busy       : a string is being scanned or sent
//   remaining  : characters still to send, including the one on out_char
//   done       : one-cycle pulse after a string completes (also for empty strings)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, the payload stays stable and valid stays
// high until that transfer; ready may change freely.
module string_byte_serializer
    import string_byte_serializer_pkg::*;
#(
    parameter int   NCHARS        = 20,
    parameter bit   SKIP_LEAD_NUL = 1'b1,
    localparam int  CW            = $clog2(NCHARS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [8*NCHARS-1:0]    load_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_char,
    output logic                   out_last,
    output logic                   busy,
    output logic [CW-1:0]          remaining,
    output logic                   done
);

    localparam int DW = CHAR_W * NCHARS;

    state_t              state_q, state_d;
    logic [DW-1:0]       shift_q, shift_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic                out_valid_q, out_valid_d;
    logic [CHAR_W-1:0]   out_char_q, out_char_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_ready_q, load_ready_d;

    logic [CHAR_W-1:0]   top_char;
    logic [DW-1:0]       shift_next;
    logic [CW-1:0]       rem_dec;

    assign top_char   = shift_q[DW-1 -: CHAR_W];
    // Constant shift by one character: plain rewiring, the head of the
    // string always sits in the top byte.
    assign shift_next = shift_q << CHAR_W;
    // Saturating decrement keeps the counter from wrapping.
    assign rem_dec    = (rem_q != '0) ? rem_q - CW'(1) : rem_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        rem_d    = rem_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid && load_ready_q) begin
                    shift_d = load_data;
                    rem_d   = CW'(NCHARS);
                    state_d = SKIP_LEAD_NUL ? ST_SCAN : ST_SEND;
                end
            end
            ST_SCAN: begin
                if (rem_q == '0) begin
                    // Whole string was padding: finish without sending.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (top_char == NUL) begin
                    shift_d = shift_next;
                    rem_d   = rem_dec;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    shift_d = shift_next;
                    rem_d   = rem_dec;
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        out_valid_d  = (state_d == ST_SEND);
        out_char_d   = out_valid_d ? shift_d[DW-1 -: CHAR_W] : NUL;
        out_last_d   = out_valid_d && (rem_d == CW'(1));
        busy_d       = (state_d != ST_IDLE);
        load_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            rem_q        <= '0;
            out_valid_q  <= 1'b0;
            out_char_q   <= NUL;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rem_q        <= rem_d;
            out_valid_q  <= out_valid_d;
            out_char_q   <= out_char_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign load_ready = load_ready_q;
    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign remaining  = rem_q;
    assign done       = done_q;

endmodule

// File: tb/tb_string_byte_serializer.sv
// Bench for string_byte_serializer: a 20-character instance that skips
// leading NULs and a 4-character instance that sends every byte.
module tb_string_byte_serializer;

    localparam int N  = 20;
    localparam int DW = 8 * N;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main instance
    logic          lv, lr, ov, ordy, ol, busy, done;
    logic [DW-1:0] ld;
    logic [7:0]    oc;
    logic [4:0]    rem;

    // no-skip instance
    logic          r_lv, r_lr, r_ov, r_ordy, r_ol, r_busy, r_done;
    logic [31:0]   r_ld;
    logic [7:0]    r_oc;
    logic [2:0]    r_rem;

    string_byte_serializer #(.NCHARS(N), .SKIP_LEAD_NUL(1'b1)) u_main (
        .clk(clk), .reset(reset),
        .load_valid(lv), .load_ready(lr), .load_data(ld),
        .out_valid(ov), .out_ready(ordy), .out_char(oc), .out_last(ol),
        .busy(busy), .remaining(rem), .done(done)
    );

    string_byte_serializer #(.NCHARS(4), .SKIP_LEAD_NUL(1'b0)) u_raw (
        .clk(clk), .reset(reset),
        .load_valid(r_lv), .load_ready(r_lr), .load_data(r_ld),
        .out_valid(r_ov), .out_ready(r_ordy), .out_char(r_oc), .out_last(r_ol),
        .busy(r_busy), .remaining(r_rem), .done(r_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // scoreboard: {last, char} per transfer
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [8:0] r_got_q[$];
    int done_cnt   = 0;
    int r_done_cnt = 0;
    int stall_err  = 0;
    int idle_err   = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_char  = 8'h00;
    logic       prev_last  = 1'b0;

    // out_ready pattern: 0 always ready, 1 toggling, 2 random
    int ready_mode = 0;
    always @(negedge clk) begin
        case (ready_mode)
            0:       ordy = 1'b1;
            1:       ordy = ~ordy;
            default: ordy = 1'($urandom_range(0, 1));
        endcase
    end

    // monitors (sample pre-edge values at the active edge)
    always @(posedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (ov && ordy) got_q.push_back({ol, oc});
            if (done) done_cnt++;
            if (prev_stall && !(ov && oc == prev_char && ol == prev_last)) stall_err++;
            if (!ov && (oc != 8'h00 || ol != 1'b0)) idle_err++;
            prev_stall = ov && !ordy;
            prev_char  = oc;
            prev_last  = ol;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (r_ov && r_ordy) r_got_q.push_back({r_ol, r_oc});
            if (r_done) r_done_cnt++;
        end
    end

    // reference model: characters first-to-last, optionally dropping leading NULs
    task automatic build_exp(input logic [DW-1:0] v, input int nch, input bit skip);
        int start;
        logic [7:0] c;
        exp_q.delete();
        start = 0;
        if (skip) begin
            while (start < nch && v[8*(nch-1-start) +: 8] == 8'h00) start++;
        end
        for (int i = start; i < nch; i++) begin
            c = v[8*(nch-1-i) +: 8];
            exp_q.push_back({1'(i == nch - 1), c});
        end
    endtask

    function automatic int first_diff(input logic [8:0] a[$], input logic [8:0] b[$]);
        int m;
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return m;
        return -1;
    endfunction

    // drivers
    task automatic load_main(input logic [DW-1:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!lr && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ld = v;
        lv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lv = 1'b0;
    endtask

    task automatic wait_done_main(input int bound, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; lv = 1'b0; ld = '0; r_lv = 1'b0; r_ld = '0;
        ordy = 1'b1; r_ordy = 1'b1; ready_mode = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ov, oc, ol} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset_out: got valid=%b char=%h last=%b exp 0/00/0", ov, oc, ol);
        end
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_busy_done: got busy=%b done=%b exp 0/0", busy, done);
        end
        tests_run++;
        if (lr !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_load_ready: got %b exp 1", lr);
        end
        tests_run++;
        if (rem !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_remaining: got %0d exp 0", rem);
        end
        tests_run++;
        if ({r_lr, r_ov, r_rem} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_raw: got ready=%b valid=%b rem=%0d exp 1/0/0", r_lr, r_ov, r_rem);
        end
    endtask

    task automatic test_abc();
        int edges, d0, idx;
        got_q.delete();
        build_exp(DW'("ABC:"), N, 1'b1);
        ready_mode = 0;
        d0 = done_cnt;
        load_main(DW'("ABC:"));
        tests_run++;
        if (rem !== 5'd20 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abc_after_load: got rem=%0d busy=%b exp 20/1", rem, busy);
        end
        edges = 0;
        while (!ov && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        tests_run++;
        if (edges != 17) begin
            tests_failed++;
            $display("FAIL abc_first_valid: got %0d edges exp 17", edges);
        end
        for (int g = 0; g < 40 && got_q.size() < 4; g++) begin
            @(posedge clk);
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abc_done_after_last: got done=%b busy=%b exp 1/0", done, busy);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || done_cnt != d0 + 1) begin
            tests_failed++;
            $display("FAIL abc_done_pulse: got done=%b pulses=%0d exp 0/1", done, done_cnt - d0);
        end
        idx = first_diff(got_q, exp_q);
        tests_run++;
        if (idx != -1) begin
            tests_failed++;
            $display("FAIL abc_stream: got %0d chars exp %0d, first diff at %0d", got_q.size(), exp_q.size(), idx);
        end
    endtask

    task automatic test_stall_hello();
        bit to;
        int idx;
        got_q.delete();
        build_exp({4{"hello"}}, N, 1'b1);
        ready_mode = 1;
        load_main({4{"hello"}});
        wait_done_main(200, to);
        ready_mode = 0;
        idx = first_diff(got_q, exp_q);
        tests_run++;
        if (to || idx != -1) begin
            tests_failed++;
            $display("FAIL hello_stream: got %0d chars timeout=%b exp %0d, first diff at %0d", got_q.size(), to, exp_q.size(), idx);
        end
        tests_run++;
        if (stall_err != 0) begin
            tests_failed++;
            $display("FAIL hello_stall_stable: got %0d unstable stalls exp 0", stall_err);
        end
        tests_run++;
        if (idle_err != 0) begin
            tests_failed++;
            $display("FAIL hello_idle_zero: got %0d nonzero idle outputs exp 0", idle_err);
        end
    endtask

    task automatic test_interior_nul();
        bit to;
        int idx;
        got_q.delete();
        build_exp(DW'(24'h410042), N, 1'b1);
        ready_mode = 2;
        load_main(DW'(24'h410042));
        wait_done_main(200, to);
        ready_mode = 0;
        idx = first_diff(got_q, exp_q);
        tests_run++;
        if (to || idx != -1) begin
            tests_failed++;
            $display("FAIL interior_nul_stream: got %0d chars timeout=%b exp 3, first diff at %0d", got_q.size(), to, idx);
        end
    endtask

    task automatic test_all_zero();
        int edges;
        bit saw_valid;
        logic prev_busy;
        got_q.delete();
        load_main('0);
        edges = 0;
        saw_valid = 1'b0;
        prev_busy = busy;
        while (!done && edges < 60) begin
            prev_busy = busy;
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (ov) saw_valid = 1'b1;
        end
        tests_run++;
        if (edges != 21) begin
            tests_failed++;
            $display("FAIL zero_done_latency: got %0d edges exp 21", edges);
        end
        tests_run++;
        if (saw_valid || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_no_output: got valid_seen=%b chars=%0d exp 0/0", saw_valid, got_q.size());
        end
        tests_run++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_busy_fall: got busy=%b before=%b exp 0/1", busy, prev_busy);
        end
    endtask

    task automatic test_no_skip();
        int idx;
        r_got_q.delete();
        build_exp(DW'(32'h0000_4142), 4, 1'b0);
        @(negedge clk);
        r_ld = 32'h0000_4142;
        r_lv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_lv = 1'b0;
        tests_run++;
        if (r_ov !== 1'b1 || r_oc !== 8'h00 || r_rem !== 3'd4) begin
            tests_failed++;
            $display("FAIL noskip_first: got valid=%b char=%h rem=%0d exp 1/00/4", r_ov, r_oc, r_rem);
        end
        for (int g = 0; g < 20 && !r_done; g++) begin
            @(posedge clk);
            @(negedge clk);
        end
        idx = first_diff(r_got_q, exp_q);
        tests_run++;
        if (!r_done || idx != -1) begin
            tests_failed++;
            $display("FAIL noskip_stream: got %0d chars done=%b exp 4, first diff at %0d", r_got_q.size(), r_done, idx);
        end
    endtask

    task automatic test_reset_abort();
        bit to;
        int d0, idx;
        got_q.delete();
        ready_mode = 0;
        load_main(DW'("XYZ:"));
        for (int g = 0; g < 60 && got_q.size() < 2; g++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ov, oc, ol, busy, done} !== 12'h0 || rem !== 5'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got valid=%b char=%h last=%b busy=%b done=%b rem=%0d exp all 0",
                     ov, oc, ol, busy, done, rem);
        end
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        build_exp(DW'("Q"), N, 1'b1);
        load_main(DW'("Q"));
        wait_done_main(60, to);
        @(posedge clk);
        @(negedge clk);
        idx = first_diff(got_q, exp_q);
        tests_run++;
        if (to || idx != -1) begin
            tests_failed++;
            $display("FAIL abort_reload_stream: got %0d chars timeout=%b exp 1, first diff at %0d", got_q.size(), to, idx);
        end
        tests_run++;
        if (done_cnt != d0 + 1) begin
            tests_failed++;
            $display("FAIL abort_done_count: got %0d pulses exp 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d0, idx, g;
        got_q.delete();
        exp_q = '{9'h061, 9'h162, 9'h063, 9'h164};
        ready_mode = 0;
        d0 = done_cnt;
        @(negedge clk);
        ld = DW'("ab");
        lv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld = DW'("cd");
        g = 0;
        while (!done && g < 60) begin
            @(posedge clk);
            @(negedge clk);
            g++;
        end
        tests_run++;
        if (done !== 1'b1 || lr !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_in_done: got done=%b ready=%b exp 1/1", done, lr);
        end
        @(posedge clk);
        @(negedge clk);
        lv = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: got busy=%b exp 1", busy);
        end
        wait_done_main(60, to);
        @(posedge clk);
        @(negedge clk);
        idx = first_diff(got_q, exp_q);
        tests_run++;
        if (to || idx != -1) begin
            tests_failed++;
            $display("FAIL b2b_stream: got %0d chars timeout=%b exp 4, first diff at %0d", got_q.size(), to, idx);
        end
        tests_run++;
        if (done_cnt != d0 + 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d pulses exp 2", done_cnt - d0);
        end
    endtask

    task automatic test_random();
        bit to;
        int k, idx, d0;
        logic [DW-1:0] v;
        for (int t = 0; t < 25; t++) begin
            k = $urandom_range(0, N);
            v = '0;
            for (int i = k; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) v[8*(N-1-i) +: 8] = 8'h00;
                else v[8*(N-1-i) +: 8] = 8'($urandom_range(1, 255));
            end
            got_q.delete();
            build_exp(v, N, 1'b1);
            ready_mode = $urandom_range(0, 2);
            d0 = done_cnt;
            load_main(v);
            wait_done_main(300, to);
            @(posedge clk);
            @(negedge clk);
            idx = first_diff(got_q, exp_q);
            tests_run++;
            if (to || idx != -1) begin
                tests_failed++;
                $display("FAIL random_stream[%0d]: got %0d chars timeout=%b exp %0d, first diff at %0d",
                         t, got_q.size(), to, exp_q.size(), idx);
            end
            tests_run++;
            if (done_cnt != d0 + 1) begin
                tests_failed++;
                $display("FAIL random_done[%0d]: got %0d pulses exp 1", t, done_cnt - d0);
            end
        end
        ready_mode = 0;
        tests_run++;
        if (stall_err != 0 || idle_err != 0) begin
            tests_failed++;
            $display("FAIL random_stability: got stall_err=%0d idle_err=%0d exp 0/0", stall_err, idle_err);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall_hello();
        test_interior_nul();
        test_all_zero();
        test_no_skip();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
